chdr_pattern_checker: RTL and testbench

Receive-side counterpart of the null source/sink block's packet generator. Consumes a CHDR data stream, checks each packet's header sequence number, length field and packet type, and checks every payload line against the generator's incrementing-index pattern. Line, packet and error statistics are exposed as status outputs for the block's register space. Instantiated on a sink port in loopback/throughput test designs.

---
 rtl/chdr_pattern_checker.sv | 167 ++++++++++++++++
 tb/tb_chdr_pattern_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/chdr_pattern_checker.sv
// Receive-side checker for the null source/sink packet generator: validates CHDR
// header SeqNum/Length/PktType and the incrementing-index payload pattern.
module chdr_pattern_checker #(
    parameter int CHDR_W    = 64,
    parameter int ERR_CNT_W = 32
) (
    input  logic                 rfnoc_chdr_clk,
    input  logic                 rfnoc_chdr_rst,
    input  logic [CHDR_W-1:0]    s_rfnoc_chdr_tdata,
    input  logic                 s_rfnoc_chdr_tlast,
    input  logic                 s_rfnoc_chdr_tvalid,
    output logic                 s_rfnoc_chdr_tready,
    input  logic                 ctrl_clear,
    output logic [63:0]          line_cnt,
    output logic [63:0]          pkt_cnt,
    output logic [ERR_CNT_W-1:0] payload_err_cnt,
    output logic [ERR_CNT_W-1:0] seq_err_cnt,
    output logic [ERR_CNT_W-1:0] len_err_cnt,
    output logic [ERR_CNT_W-1:0] type_err_cnt,
    output logic                 err_flag
);

    localparam int         BYTES    = CHDR_W / 8;
    localparam int         BYTES_W  = $clog2(BYTES);
    localparam int         REPS     = CHDR_W / 32;
    localparam logic [2:0] TYPE_DATA = 3'd6;

    typedef enum logic [1:0] {HDR, MDATA, PYLD, DROP} state_t;

    typedef struct packed {
        logic [2:0]  pkt_type;
        logic [4:0]  num_mdata;
        logic [15:0] seq_num;
        logic [15:0] length;
    } chdr_hdr_t;

    state_t      state, state_nxt;
    logic [15:0] beat_cnt, beat_cnt_nxt;
    logic [15:0] exp_beats, exp_beats_nxt;
    logic [4:0]  mdata_left, mdata_left_nxt;
    logic [15:0] exp_seq, exp_seq_nxt;
    logic [15:0] exp_idx, exp_idx_nxt;

    logic        accept;
    chdr_hdr_t   hdr;
    logic [16:0] len_round;
    logic [15:0] hdr_beats;
    logic [CHDR_W-1:0] pattern;

    logic        line_inc, pkt_inc, payload_err, seq_err, len_err, type_err, dropped;
    logic [15:0] cur_cnt, cur_exp;

    assign accept    = s_rfnoc_chdr_tvalid && s_rfnoc_chdr_tready;
    assign hdr       = chdr_hdr_t'(s_rfnoc_chdr_tdata[55:16]);
    assign len_round = {1'b0, hdr.length} + 17'(BYTES - 1);
    assign hdr_beats = 16'(len_round >> BYTES_W);
    assign pattern   = {REPS{~exp_idx, exp_idx}};

    always_comb begin
        state_nxt      = state;
        beat_cnt_nxt   = beat_cnt;
        exp_beats_nxt  = exp_beats;
        mdata_left_nxt = mdata_left;
        exp_seq_nxt    = exp_seq;
        exp_idx_nxt    = exp_idx;
        line_inc       = 1'b0;
        pkt_inc        = 1'b0;
        payload_err    = 1'b0;
        seq_err        = 1'b0;
        len_err        = 1'b0;
        type_err       = 1'b0;
        dropped        = (state == DROP);
        // Beat count including the current beat, used by the tlast length check
        cur_cnt        = beat_cnt + 16'd1;
        cur_exp        = exp_beats;
        if (accept) begin
            case (state)
                HDR: begin
                    cur_cnt        = 16'd1;
                    cur_exp        = hdr_beats;
                    beat_cnt_nxt   = 16'd1;
                    exp_beats_nxt  = hdr_beats;
                    mdata_left_nxt = hdr.num_mdata;
                    if (hdr.pkt_type != TYPE_DATA) begin
                        type_err  = 1'b1;
                        dropped   = 1'b1;
                        state_nxt = DROP;
                    end else begin
                        seq_err     = (hdr.seq_num != exp_seq);
                        exp_seq_nxt = hdr.seq_num + 16'd1;
                        state_nxt   = (hdr.num_mdata != 5'd0) ? MDATA : PYLD;
                    end
                end
                MDATA: begin
                    beat_cnt_nxt   = cur_cnt;
                    mdata_left_nxt = mdata_left - 5'd1;
                    if (mdata_left == 5'd1) state_nxt = PYLD;
                end
                PYLD: begin
                    beat_cnt_nxt = cur_cnt;
                    line_inc     = 1'b1;
                    if (s_rfnoc_chdr_tdata == pattern) begin
                        exp_idx_nxt = exp_idx + 16'd1;
                    end else begin
                        // Resync on the received index so one bad line costs one error
                        payload_err = 1'b1;
                        exp_idx_nxt = s_rfnoc_chdr_tdata[15:0] + 16'd1;
                    end
                end
                DROP: beat_cnt_nxt = cur_cnt;
                default: state_nxt = HDR;
            endcase
            if (s_rfnoc_chdr_tlast) begin
                pkt_inc   = 1'b1;
                len_err   = !dropped && (cur_cnt != cur_exp);
                state_nxt = HDR;
            end
        end
    end

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c,
                                                     input logic en);
        return (en && c != '1) ? c + ERR_CNT_W'(1) : c;
    endfunction

    // Framing state survives ctrl_clear so packet alignment is kept
    always_ff @(posedge rfnoc_chdr_clk) begin
        if (rfnoc_chdr_rst) begin
            s_rfnoc_chdr_tready <= 1'b0;
            state               <= HDR;
            beat_cnt            <= '0;
            exp_beats           <= '0;
            mdata_left          <= '0;
        end else begin
            s_rfnoc_chdr_tready <= 1'b1;
            state               <= state_nxt;
            beat_cnt            <= beat_cnt_nxt;
            exp_beats           <= exp_beats_nxt;
            mdata_left          <= mdata_left_nxt;
        end
    end

    always_ff @(posedge rfnoc_chdr_clk) begin
        if (rfnoc_chdr_rst || ctrl_clear) begin
            exp_seq         <= '0;
            exp_idx         <= '0;
            line_cnt        <= '0;
            pkt_cnt         <= '0;
            payload_err_cnt <= '0;
            seq_err_cnt     <= '0;
            len_err_cnt     <= '0;
            type_err_cnt    <= '0;
            err_flag        <= 1'b0;
        end else begin
            exp_seq         <= exp_seq_nxt;
            exp_idx         <= exp_idx_nxt;
            line_cnt        <= line_inc ? line_cnt + 64'd1 : line_cnt;
            pkt_cnt         <= pkt_inc ? pkt_cnt + 64'd1 : pkt_cnt;
            payload_err_cnt <= sat_inc(payload_err_cnt, payload_err);
            seq_err_cnt     <= sat_inc(seq_err_cnt, seq_err);
            len_err_cnt     <= sat_inc(len_err_cnt, len_err);
            type_err_cnt    <= sat_inc(type_err_cnt, type_err);
            if (payload_err || seq_err || len_err || type_err) err_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_chdr_pattern_checker.sv
// Directed bench for chdr_pattern_checker: packet-level vector table plus
// hand sequences for reset, mid-packet clear and index/sequence wrap.
module tb_chdr_pattern_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] tdata;
    logic        tlast, tvalid, tready, ctrl_clear;
    logic [63:0] line_cnt, pkt_cnt;
    logic [31:0] payload_err_cnt, seq_err_cnt, len_err_cnt, type_err_cnt;
    logic        err_flag;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] gidx;
    logic        gaps_en;

    always #5 clk = ~clk;

    chdr_pattern_checker #(.CHDR_W(64), .ERR_CNT_W(32)) dut (
        .rfnoc_chdr_clk      (clk),
        .rfnoc_chdr_rst      (rst),
        .s_rfnoc_chdr_tdata  (tdata),
        .s_rfnoc_chdr_tlast  (tlast),
        .s_rfnoc_chdr_tvalid (tvalid),
        .s_rfnoc_chdr_tready (tready),
        .ctrl_clear          (ctrl_clear),
        .line_cnt            (line_cnt),
        .pkt_cnt             (pkt_cnt),
        .payload_err_cnt     (payload_err_cnt),
        .seq_err_cnt         (seq_err_cnt),
        .len_err_cnt         (len_err_cnt),
        .type_err_cnt        (type_err_cnt),
        .err_flag            (err_flag)
    );

    typedef struct {
        logic [15:0] seq;
        logic [15:0] len;
        logic [2:0]  ptype;
        logic [4:0]  nmd;
        int          nlines;
        int          cline;
        int          cbit;
        int          e_line;
        int          e_pkt;
        int          e_perr;
        int          e_serr;
        int          e_lerr;
        int          e_terr;
        logic        e_flag;
    } vec_t;

    vec_t rows[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int el, input int ep, input int epe,
                             input int ese, input int ele, input int ete, input logic ef);
        check({tag, ".line_cnt"}, line_cnt, 64'(el));
        check({tag, ".pkt_cnt"}, pkt_cnt, 64'(ep));
        check({tag, ".payload_err"}, 64'(payload_err_cnt), 64'(epe));
        check({tag, ".seq_err"}, 64'(seq_err_cnt), 64'(ese));
        check({tag, ".len_err"}, 64'(len_err_cnt), 64'(ele));
        check({tag, ".type_err"}, 64'(type_err_cnt), 64'(ete));
        check({tag, ".err_flag"}, 64'(err_flag), 64'(ef));
    endtask

    // Entered and left at posedge+1; the beat is accepted on the next edge
    task automatic send_beat(input logic [63:0] d, input logic l, input logic clr);
        if (gaps_en && $urandom_range(0, 3) == 0) begin
            tvalid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        tdata = d; tlast = l; tvalid = 1'b1; ctrl_clear = clr;
        @(posedge clk);
        #1;
        tvalid = 1'b0; tlast = 1'b0; ctrl_clear = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] seq, input logic [15:0] len,
                            input logic [2:0] ptype, input logic [4:0] nmd,
                            input int nlines, input int cline, input int cbit,
                            input int clr_at);
        logic [15:0] idx;
        logic [63:0] d;
        send_beat({8'h00, ptype, nmd, seq, len, 16'h0000}, (nlines == 0 && nmd == 0), 1'b0);
        for (int m = 0; m < int'(nmd); m++)
            send_beat(64'hA5A5_0000_0000_0000 | 64'(m), (m == int'(nmd) - 1 && nlines == 0), 1'b0);
        idx = gidx;
        for (int k = 0; k < nlines; k++) begin
            d = {2{~idx, idx}};
            if (k == cline) d[cbit] = ~d[cbit];
            send_beat(d, (k == nlines - 1), (k == clr_at));
            if (k == clr_at) check_all("clear_mid", 0, 0, 0, 0, 0, 0, 1'b0);
            idx = idx + 16'd1;
        end
        // Dropped packets do not advance the generator index the checker expects
        if (ptype == 3'd6) gidx = idx;
    endtask

    initial begin
        // Cumulative expectations, starting from a cleared checker with index 0.
        // Row 2 corrupts the ~i half (bit 19): one error. Row 9 flips bit 3 of i,
        // so the resync lands on the wrong index and the next line also misses.
        rows[0]  = '{16'd0,  16'd808, 3'd6, 5'd0, 100, -1,  0, 100, 1,  0, 0, 0, 0, 1'b0};
        rows[1]  = '{16'd1,  16'd808, 3'd6, 5'd0, 100, -1,  0, 200, 2,  0, 0, 0, 0, 1'b0};
        rows[2]  = '{16'd2,  16'd808, 3'd6, 5'd0, 100, 37, 19, 300, 3,  1, 0, 0, 0, 1'b1};
        rows[3]  = '{16'd4,  16'd808, 3'd6, 5'd0, 100, -1,  0, 400, 4,  1, 1, 0, 0, 1'b1};
        rows[4]  = '{16'd5,  16'd808, 3'd6, 5'd0, 100, -1,  0, 500, 5,  1, 1, 0, 0, 1'b1};
        rows[5]  = '{16'd6,  16'd808, 3'd6, 5'd0,  99, -1,  0, 599, 6,  1, 1, 1, 0, 1'b1};
        rows[6]  = '{16'd7,  16'd808, 3'd7, 5'd0, 100, -1,  0, 599, 7,  1, 1, 1, 1, 1'b1};
        rows[7]  = '{16'd7,  16'd824, 3'd6, 5'd2, 100, -1,  0, 699, 8,  1, 1, 1, 1, 1'b1};
        rows[8]  = '{16'd8,  16'd8,   3'd6, 5'd0,   0, -1,  0, 699, 9,  1, 1, 1, 1, 1'b1};
        rows[9]  = '{16'd9,  16'd808, 3'd6, 5'd0, 100, 10,  3, 799, 10, 3, 1, 1, 1, 1'b1};
        rows[10] = '{16'd10, 16'd808, 3'd6, 5'd0, 101, -1,  0, 900, 11, 3, 1, 2, 1, 1'b1};
        rows[11] = '{16'd11, 16'd16,  3'd6, 5'd0,   0, -1,  0, 900, 12, 3, 1, 3, 1, 1'b1};

        rst = 1'b1; tdata = '0; tlast = 1'b0; tvalid = 1'b0; ctrl_clear = 1'b0;
        gidx = '0; gaps_en = 1'b0;

        // Reset
        repeat (4) @(posedge clk);
        #1;
        check("rst.tready", 64'(tready), 64'd0);
        check_all("rst", 0, 0, 0, 0, 0, 0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst.tready", 64'(tready), 64'd1);

        // Nominal traffic with random tvalid gaps
        gaps_en = 1'b1;
        for (int p = 0; p < 50; p++)
            send_pkt(16'(p), 16'd808, 3'd6, 5'd0, 100, -1, 0, -1);
        check_all("nominal", 5000, 50, 0, 0, 0, 0, 1'b0);

        // Idle clear
        ctrl_clear = 1'b1;
        @(posedge clk);
        #1;
        ctrl_clear = 1'b0;
        check_all("idle_clear", 0, 0, 0, 0, 0, 0, 1'b0);
        gidx = '0;

        // Table of packets
        for (int r = 0; r < 12; r++) begin
            send_pkt(rows[r].seq, rows[r].len, rows[r].ptype, rows[r].nmd, rows[r].nlines,
                     rows[r].cline, rows[r].cbit, -1);
            check_all($sformatf("row%0d", r), rows[r].e_line, rows[r].e_pkt, rows[r].e_perr,
                      rows[r].e_serr, rows[r].e_lerr, rows[r].e_terr, rows[r].e_flag);
        end

        // Clear coincident with payload line 50: that beat is discarded, line 51
        // mismatches the reset index once, framing and length stay intact
        send_pkt(16'd12, 16'd808, 3'd6, 5'd0, 100, -1, 0, 50);
        check_all("after_clear", 49, 1, 1, 0, 0, 0, 1'b1);
        send_pkt(16'd0, 16'd808, 3'd6, 5'd0, 100, -1, 0, -1);
        check_all("post_clear_seq0", 149, 2, 1, 0, 0, 0, 1'b1);

        // Wrap: a one-line priming packet resyncs index to 65500 and seq to 65535
        gidx = 16'd65499;
        send_pkt(16'd65534, 16'd16, 3'd6, 5'd0, 1, -1, 0, -1);
        check_all("wrap_prime", 150, 3, 2, 1, 0, 0, 1'b1);
        send_pkt(16'd65535, 16'd808, 3'd6, 5'd0, 100, -1, 0, -1);
        send_pkt(16'd0, 16'd808, 3'd6, 5'd0, 100, -1, 0, -1);
        check_all("wrap", 350, 5, 2, 1, 0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
